// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared FSM state type, error codes and default parameters
// for the UART command frame parser.
package uart_cmd_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, CSUM} state_t;

    localparam logic [1:0] ERR_CSUM        = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT     = 2'b10;
    localparam logic [7:0] HEADER_DEF      = 8'h55;
    localparam int         TIMEOUT_CYC_DEF = 50000;

endpackage

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer: inter-byte timeout counter; expire_o is high in the cycle
// the count reaches TIMEOUT_CYC-1 while enabled and not being cleared.
module uart_cmd_timer
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = clear_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
        expire_o = en_i && !clear_i && (cnt_q == W'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: HEADER/ADDR/DATA/CSUM frame parser driving a register write strobe.
// Inter-byte timeout is built only when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] HEADER      = HEADER_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    state_t     state_q, state_d;
    logic       rx_valid_q;
    logic [7:0] addr_q, addr_d, data_q, data_d;
    logic [7:0] reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
    logic       we_q, we_d, err_q, err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] csum;
    logic       byte_acc, expire;

    assign byte_acc = rx_valid && !rx_valid_q;
    assign csum     = addr_q + data_q;

`ifdef UART_CMD_TIMEOUT_EN
    uart_cmd_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk_i   (CLK_50M),
        .rst_ni  (RST_N),
        .clear_i (byte_acc || state_q == IDLE),
        .en_i    (state_q != IDLE),
        .expire_o(expire)
    );
`else
    // No timer: a partial frame waits indefinitely.
    assign expire = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        we_d        = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        if (byte_acc) begin
            case (state_q)
                IDLE: state_d = (rx_data == HEADER) ? ADDR : IDLE;
                ADDR: begin
                    addr_d  = rx_data;
                    state_d = DATA;
                end
                DATA: begin
                    data_d  = rx_data;
                    state_d = CSUM;
                end
                CSUM: begin
                    state_d = IDLE;
                    if (rx_data == csum) begin
                        we_d        = 1'b1;
                        reg_addr_d  = addr_q;
                        reg_wdata_d = data_q;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (expire) begin
            // A byte in the same cycle wins over the timeout.
            state_d    = IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            rx_valid_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            rx_valid_q  <= rx_valid;
            addr_q      <= addr_d;
            data_q      <= data_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            we_q        <= we_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = we_q;
    assign frame_err = err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed frames with a strobe scoreboard; expected writes
// and errors are queued as stimulus is driven and popped on each DUT strobe.
module tb_uart_cmd_parser;

    localparam int TO = 40;

    typedef struct {
        logic       err;
        logic [7:0] a;
        logic [7:0] d;
        logic [1:0] code;
    } ev_t;

    logic       CLK_50M = 1'b0;
    logic       RST_N;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] reg_addr, reg_wdata;
    logic       reg_we, frame_err, busy;
    logic [1:0] err_code;

    int   n_checks = 0;
    int   n_fail   = 0;
    ev_t  q[$];
    ev_t  mon_e;

    uart_cmd_parser #(.HEADER(8'h55), .TIMEOUT_CYC(TO)) dut (
        .CLK_50M  (CLK_50M),
        .RST_N    (RST_N),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .frame_err(frame_err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #10 CLK_50M = ~CLK_50M;

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(logic [7:0] a, logic [7:0] d);
        ev_t e;
        e.err = 1'b0; e.a = a; e.d = d; e.code = 2'b00;
        q.push_back(e);
    endtask

    task automatic push_err(logic [1:0] code);
        ev_t e;
        e.err = 1'b1; e.a = 8'h00; e.d = 8'h00; e.code = code;
        q.push_back(e);
    endtask

    task automatic send(logic [7:0] b, int hold = 1);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (hold) @(posedge CLK_50M);
        #1 rx_valid = 1'b0;
        repeat (2) @(posedge CLK_50M);
        #1;
    endtask

    task automatic send4(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3, int hold = 1);
        send(b0, hold); send(b1, hold); send(b2, hold); send(b3, hold);
    endtask

    task automatic drain(string tag);
        repeat (4) @(posedge CLK_50M);
        #1;
        check(tag, 16'(q.size()), 16'd0);
    endtask

    always @(negedge CLK_50M) begin
        if (RST_N === 1'b1 && (reg_we === 1'b1 || frame_err === 1'b1)) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", {14'd0, reg_we, frame_err}, 16'd0);
            end else begin
                mon_e = q.pop_front();
                check("strobe_kind", {14'd0, reg_we, frame_err}, mon_e.err ? 16'd1 : 16'd2);
                if (mon_e.err) begin
                    check("err_code", {14'd0, err_code}, {14'd0, mon_e.code});
                end else begin
                    check("wr_addr", {8'd0, reg_addr}, {8'd0, mon_e.a});
                    check("wr_data", {8'd0, reg_wdata}, {8'd0, mon_e.d});
                end
            end
        end
    end

    initial begin
        RST_N    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(posedge CLK_50M);
        #1;
        check("rst_outputs", {reg_addr, reg_wdata}, 16'h0000);
        check("rst_flags", {11'd0, reg_we, frame_err, err_code, busy}, 16'd0);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK_50M);
        #1;

        push_wr(8'h12, 8'h34);
        send4(8'h55, 8'h12, 8'h34, 8'h46);
        drain("good_frame_drain");
        check("good_frame_busy", {15'd0, busy}, 16'd0);

        push_err(2'b01);
        send4(8'h55, 8'h12, 8'h34, 8'h47);
        drain("bad_csum_drain");
        check("bad_csum_hold", {reg_addr, reg_wdata}, 16'h1234);
        check("bad_csum_code", {14'd0, err_code}, 16'd1);

        push_wr(8'hF0, 8'h20);
        send(8'hAA);
        send(8'h00);
        check("resync_idle", {15'd0, busy}, 16'd0);
        send4(8'h55, 8'hF0, 8'h20, 8'h10);
        drain("wrap_drain");
        check("code_held", {14'd0, err_code}, 16'd1);

        push_wr(8'h01, 8'h02);
        send4(8'h55, 8'h01, 8'h02, 8'h03, 5);
        drain("held_valid_drain");
        check("held_valid_regs", {reg_addr, reg_wdata}, 16'h0102);

        push_wr(8'h55, 8'h55);
        send4(8'h55, 8'h55, 8'h55, 8'hAA);
        drain("hdr_payload_drain");

        send(8'h55);
        send(8'h12);
        check("partial_busy", {15'd0, busy}, 16'd1);
`ifdef UART_CMD_TIMEOUT_EN
        push_err(2'b10);
        repeat (TO + 5) @(posedge CLK_50M);
        #1;
        check("timeout_drain", 16'(q.size()), 16'd0);
        check("timeout_busy", {15'd0, busy}, 16'd0);
        check("timeout_code", {14'd0, err_code}, 16'd2);
        push_wr(8'h01, 8'h01);
        send4(8'h55, 8'h01, 8'h01, 8'h02);
        drain("after_timeout_drain");
        send(8'h55);
        send(8'h12);
`else
        repeat (3 * TO) @(posedge CLK_50M);
        #1;
        check("no_timeout_busy", {15'd0, busy}, 16'd1);
`endif
        RST_N = 1'b0;
        #2;
        check("async_rst_busy", {15'd0, busy}, 16'd0);
        check("async_rst_regs", {reg_addr, reg_wdata}, 16'h0000);
        check("async_rst_flags", {12'd0, reg_we, frame_err, err_code}, 16'd0);
        @(posedge CLK_50M);
        #1 RST_N = 1'b1;
        @(posedge CLK_50M);
        #1;
        push_wr(8'h03, 8'h04);
        send4(8'h55, 8'h03, 8'h04, 8'h07);
        drain("post_rst_drain");
        check("post_rst_regs", {reg_addr, reg_wdata}, 16'h0304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter HEADER, default 8'h55, the frame start byte.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, the inter-byte timeout in clock cycles (1 ms at 50 MHz).
REQ-003 SHALL have port CLK_50M  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rx_valid  input  1  byte-done flag from the UART receiver; high one or more cycles per byte.
REQ-007 SHALL have port reg_addr  output  8  register address of the last good frame.
REQ-008 SHALL have port reg_wdata  output  8  register write data of the last good frame.
REQ-009 SHALL have port reg_we  output  1  one-cycle write strobe.
REQ-010 SHALL have port frame_err  output  1  one-cycle error strobe.
REQ-011 SHALL have port err_code  output  2  cause of the last error: 2'b01 checksum, 2'b10 timeout.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL accept one byte per rising edge of rx_valid (0 in previous cycle, 1 in current cycle), using an internal one-cycle delay register; a multi-cycle-high rx_valid SHALL count as one byte.
REQ-014 SHALL implement FSM states IDLE, ADDR, DATA, CSUM.
REQ-015 Transitions on an accepted byte:
- IDLE: byte == HEADER goes to ADDR; any other byte stays in IDLE with no error (resync).
- ADDR: latches the address and goes to DATA.
- DATA: latches the data and goes to CSUM.
- CSUM: always returns to IDLE.
REQ-016 A checksum byte equal to (addr + data) mod 256, 8-bit wrap, SHALL complete a good frame.
REQ-017 On a good frame, reg_addr and reg_wdata SHALL update and reg_we SHALL pulse high in the cycle after the accepting clock edge, for exactly one cycle.
REQ-018 On a bad checksum, reg_we SHALL stay low, reg_addr and reg_wdata SHALL hold, frame_err SHALL pulse one cycle, and err_code SHALL become 2'b01, with the same timing as reg_we.
REQ-019 reg_addr and reg_wdata SHALL hold their values between good frames.
REQ-020 err_code SHALL hold until the next error.
REQ-021 A HEADER-valued byte arriving in ADDR, DATA or CSUM SHALL be treated as payload, not as a restart.
REQ-022 rx_valid edges SHALL be ignored during the cycle the write or error strobe is asserted only if they are not rising edges; no accepted byte SHALL ever be dropped.

Reset
REQ-023 On RST_N low, the FSM SHALL go to IDLE immediately, including mid-frame, discarding the partial frame.
REQ-024 On RST_N low, reg_addr, reg_wdata and err_code SHALL be 0; reg_we, frame_err and busy SHALL be 0; the edge-detect register SHALL be 0.
REQ-025 No strobe SHALL be issued in the first cycle after reset release.

Configuration
REQ-026 Macro UART_CMD_TIMEOUT_EN SHALL control the inter-byte timeout.
- Defined: a counter clears on every accepted byte and in IDLE, and counts every cycle in ADDR, DATA and CSUM. On reaching TIMEOUT_CYC-1 the FSM SHALL go to IDLE, frame_err SHALL pulse one cycle, and err_code SHALL become 2'b10.
- Defined, simultaneous byte and timeout in the same cycle: the byte wins and no timeout is raised.
- Undefined: no counter is built, a partial frame waits indefinitely, and err_code 2'b10 never occurs.

Structure
REQ-027 Shared package uart_cmd_pkg SHALL hold:
- the FSM state typedef;
- err_code constants ERR_CSUM and ERR_TIMEOUT;
- default HEADER and TIMEOUT_CYC constants.
REQ-028 The timeout counter SHALL be sub-module uart_cmd_timer, with clear, enable and expire ports, instantiated only under UART_CMD_TIMEOUT_EN.

Verification
REQ-029 Bytes 55,12,34,46 -> one reg_we pulse; reg_addr=8'h12, reg_wdata=8'h34; frame_err stays 0.
REQ-030 Bytes 55,12,34,47 -> no reg_we; frame_err pulse; err_code=2'b01; reg_addr and reg_wdata unchanged.
REQ-031 Bytes AA,00,55,F0,20,10 -> one write with addr F0, data 20 (checksum wraps 0x110 -> 0x10); leading AA,00 ignored.
REQ-032 rx_valid held high 5 cycles per byte for frame 55,01,02,03 -> exactly one reg_we, addr 01, data 02.
REQ-033 With UART_CMD_TIMEOUT_EN, bytes 55,12 then idle TIMEOUT_CYC cycles -> frame_err with err_code=2'b10 and busy=0; following frame 55,01,01,02 -> write accepted.
REQ-034 RST_N pulsed low after bytes 55,12 -> busy=0 and all outputs at reset values; then 55,03,04,07 -> write addr 03, data 04.
